mio_bus_bridge: RTL
===================

// Module: mio_bus_bridge
// PURPOSE
//  Parametrised, registered successor to the combinational MIO decoder. It sits between the CPU data port and NUM_SLV
//  memory-mapped peripherals (RAM, GPIO, counter, VGA). Each access runs as a req/ready handshake: decode is registered
//  and slaves may insert wait states through slv_ack. Accesses that hit no region, or whose slave does not acknowledge
//  within TIMEOUT cycles, complete with an error flag, and the bridge counts them.
// PARAMETERS
//  NUM_SLV   4              number of slave channels, index 0 = highest decode priority
//  ADDR_W    10             width of the word address forwarded to slaves
//  SLV_BASE  {F0000004,F0000000,E0000000,00000000}  flattened base address; slave k occupies [32k+31:32k]
//  SLV_MASK  {F0000004,F0000004,F0000000,F0000000}  flattened compare mask, same packing
//  TIMEOUT   16             max wait cycles in ACCESS before error; 0 disables the timeout
//  CNT_W     16             width of the error counter
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous reset, active-low
//  cpu_req      in   1              CPU access request; held until bus_ready
//  mem_w        in   1              1 = write, 0 = read
//  addr_bus     in   32             CPU byte address
//  Cpu_data2bus in   32             CPU write data
//  Cpu_data4bus out  32             read data returned to the CPU
//  bus_ready    out  1              one-cycle completion strobe
//  bus_err      out  1              completion was a decode miss or a timeout; valid with bus_ready
//  err_cnt      out  CNT_W          saturating count of error completions
//  slv_sel      out  NUM_SLV        one-hot slave select
//  slv_we       out  1              write enable, qualified by slv_sel
//  slv_addr     out  ADDR_W         word address addr_lat[ADDR_W+1:2]
//  slv_wdata    out  32             latched write data
//  slv_rdata    in   32*NUM_SLV     flattened slave read data, slave k at [32k+31:32k]
//  slv_ack      in   NUM_SLV        slave k done; sampled only while slv_sel[k]=1
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output = 0, including Cpu_data4bus and err_cnt. A transfer in flight is
//    abandoned. Its slave sees slv_sel drop immediately.
//  Decode: hit[k] = ((addr_bus & MASK[k]) == BASE[k]). The lowest hit index wins. No hit = miss.
//  FSM with three states: IDLE, ACCESS, RESP.
//  IDLE: cpu_req is sampled only here. On cpu_req=1 the bridge latches addr, data and mem_w.
//    On a hit it moves to ACCESS with slv_sel[k] set; on a miss it moves to RESP with err=1.
//  ACCESS: slv_sel, slv_we, slv_addr and slv_wdata are held stable and the wait counter increments each cycle.
//    slv_ack[k]=1 -> RESP; on a read, Cpu_data4bus is captured from slave k, on a write it is cleared to 0.
//    If the wait counter reaches TIMEOUT with no ack (TIMEOUT != 0) -> RESP with err=1 and Cpu_data4bus=0.
//    If ack and timeout expiry fall in the same cycle, the ack wins and the access ends without error.
//    Acks from slaves that are not selected are ignored.
//  RESP: bus_ready=1 for exactly one cycle and bus_err=err; slv_sel=0. Next state is IDLE, always.
//    If err=1, err_cnt increments and saturates at all-ones.
//  Latency from the cpu_req edge to bus_ready: miss = 1 cycle; zero-wait slave = 2 cycles; n waits = 2+n cycles;
//    timeout = TIMEOUT+2 cycles.
//  Back-to-back transfers: one transfer per at least 3 cycles, because IDLE is always visited between transfers.
//  Cpu_data4bus holds its value until the next RESP; bus_err is 0 outside RESP.
//  cpu_req dropping mid-access does not abort the access. The response is still issued.
//  All outputs are registered. There is no combinational path from addr_bus to slv_*.
// TESTING
//  1. Read of 0x00000010 with slave0 acking in the first ACCESS cycle, rdata0=0xCAFE0001 ->
//     slv_sel=0001 and slv_addr=4; bus_ready 2 cycles after req with Cpu_data4bus=0xCAFE0001 and bus_err=0.
//  2. Write 0x12345678 to 0xF0000004 -> slave3 selected (not slave2), slv_we=1, slv_wdata=0x12345678;
//     the ack after 3 waits gives bus_ready at cycle 5 and Cpu_data4bus=0.
//  3. Read of 0x50000000 (no region) -> bus_ready 1 cycle later, bus_err=1, err_cnt 0->1, no slv_sel pulse.
//  4. Slave1 never acks, TIMEOUT=16 -> bus_ready at cycle 18 with bus_err=1, Cpu_data4bus=0;
//     repeat with the ack on the 16th wait cycle -> bus_err=0.
//  5. rst pulled low during ACCESS -> slv_sel and all outputs 0 asynchronously; after release, a new read completes normally.
//  6. Force 2^CNT_W+2 misses -> err_cnt stays at all-ones; back-to-back zero-wait reads -> bus_ready every 3rd cycle.

Source files
------------

// File: rtl/mio_bus_bridge.sv
// Registered CPU-to-peripheral bridge: priority address decode, req/ready handshake,
// slave wait states via slv_ack, timeout and decode-miss errors with a saturating error counter.
module mio_bus_bridge #(
    parameter int                      NUM_SLV  = 4,
    parameter int                      ADDR_W   = 10,
    parameter logic [32*NUM_SLV-1:0]   SLV_BASE = {32'hF000_0004, 32'hF000_0000, 32'hE000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLV-1:0]   SLV_MASK = {32'hF000_0004, 32'hF000_0004, 32'hF000_0000, 32'hF000_0000},
    parameter int                      TIMEOUT  = 16,
    parameter int                      CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   mem_w,
    input  logic [31:0]            addr_bus,
    input  logic [31:0]            Cpu_data2bus,
    output logic [31:0]            Cpu_data4bus,
    output logic                   bus_ready,
    output logic                   bus_err,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [NUM_SLV-1:0]     slv_sel,
    output logic                   slv_we,
    output logic [ADDR_W-1:0]      slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    input  logic [NUM_SLV-1:0]     slv_ack
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_found;
    logic [31:0]         sel_rdata;
    logic                ack_hit;
    logic                timeout_hit;
    logic [CNT_W-1:0]    cnt_inc;

    // Lowest-index matching region wins; dec_sel stays one-hot or zero on a miss.
    always_comb begin
        dec_sel   = '0;
        dec_found = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (!dec_found &&
                ((addr_bus & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32])) begin
                dec_sel[k] = 1'b1;
                dec_found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | slv_rdata[32*k +: 32];
            end
        end
    end

    assign ack_hit     = |(slv_ack & sel_q);
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        wait_d  = wait_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = addr_bus[ADDR_W+1:2];
                    wdata_d = Cpu_data2bus;
                    wait_d  = '0;
                    if (dec_found) begin
                        sel_d   = dec_sel;
                        we_d    = mem_w;
                        state_d = ACCESS;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        cnt_d   = cnt_inc;
                        state_d = RESP;
                    end
                end
            end

            // An ack landing in the same cycle as timeout expiry takes precedence.
            ACCESS: begin
                if (ack_hit) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    ready_d = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                sel_d   = '0;
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    assign Cpu_data4bus = rdata_q;
    assign bus_ready    = ready_q;
    assign bus_err      = err_q;
    assign err_cnt      = cnt_q;
    assign slv_sel      = sel_q;
    assign slv_we       = we_q;
    assign slv_addr     = addr_q;
    assign slv_wdata    = wdata_q;

endmodule
